// File: rtl/retta_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : retta_pkg
//  Purpose  : Shared definitions for the point-table arbiter: default table
//             geometry, arbiter state encoding and the constant contents of
//             the 16x8 line-check coordinate table.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package retta_pkg;

    localparam int RETTA_AW    = 4;
    localparam int RETTA_DW    = 8;
    localparam int RETTA_DEPTH = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SERVE  = 2'd1,
        S_LOCKED = 2'd2
    } arb_state_t;

    // Element [n] holds the word at address n (listed here from address 15
    // down to address 0).
    localparam logic [RETTA_DEPTH-1:0][RETTA_DW-1:0] RETTA_MEM_INIT = {
        8'd2,   8'd0,   8'd2,   8'd0,     // 15..12
        8'd5,   8'd255, 8'd2,   8'd0,     // 11..8
        8'd0,   8'd0,   8'd2,   8'd0,     //  7..4
        8'd0,   8'd0,   8'd255, 8'd1      //  3..0
    };

endpackage
`default_nettype wire

// File: rtl/retta_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : retta_rr_pick
//  Purpose  : Combinational round-robin picker. Searches for the first
//             asserted request starting at rr_ptr+1 (modulo NREQ) and
//             returns a one-hot grant, or zero when nothing is requested.
//  Ports    : req    in  NREQ  request vector
//             rr_ptr in  PW    index of the most recent winner
//             gnt    out NREQ  one-hot grant
//  Revision : 1.0 - initial release
// ============================================================================
module retta_rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] gnt
);

    logic w_found;

    // One search chain per possible pointer value keeps every bit index a
    // compile-time constant; only the chain matching rr_ptr is active.
    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            if (rr_ptr == r[PW-1:0]) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (!w_found && req[(r + k) % NREQ]) begin
                        gnt[(r + k) % NREQ] = 1'b1;
                        w_found             = 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/retta_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : retta_mem_arbiter
//  Purpose  : Shares the single-read-port point table between NREQ scan
//             engines. Round-robin arbitration with an optional lock so one
//             engine can issue back-to-back reads; a lock is force-released
//             after LOCK_MAX consecutive grants. Read data is registered and
//             returned one cycle after the grant with a per-requester valid.
//  Ports    : clock    in  1          rising-edge clock
//             reset_n  in  1          asynchronous active-low reset
//             wr_en    in  1          table write strobe   (RETTA_ARB_WR_EN)
//             wr_addr  in  AW         table write address  (RETTA_ARB_WR_EN)
//             wr_data  in  DW         table write data     (RETTA_ARB_WR_EN)
//             req      in  NREQ       level request, held until granted
//             addr     in  NREQ*AW    requester i at [i*AW +: AW]
//             lock     in  NREQ       keep ownership after this grant
//             gnt      out NREQ       combinational one-hot grant
//             rdata    out DW         registered read data
//             rvalid   out NREQ       registered one-hot data owner
//             owner    out PW         lock owner (meaningful when locked)
//             locked   out 1          arbiter is in the locked state
//  Config   : RETTA_ARB_WR_EN - adds the write port; the table becomes
//             registers reloaded with the constant contents on reset and a
//             write cycle suppresses all grants.
//  Revision : 1.0 - initial release
// ============================================================================
module retta_mem_arbiter
    import retta_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int AW       = RETTA_AW,
    parameter int DW       = RETTA_DW,
    parameter int LOCK_MAX = 3
) (
    input  logic                    clock,
    input  logic                    reset_n,
`ifdef RETTA_ARB_WR_EN
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [DW-1:0]           wr_data,
`endif
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*AW-1:0]      addr,
    input  logic [NREQ-1:0]         lock,
    output logic [NREQ-1:0]         gnt,
    output logic [DW-1:0]           rdata,
    output logic [NREQ-1:0]         rvalid,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    locked
);

    localparam int PW    = $clog2(NREQ);
    localparam int DEPTH = 2 ** AW;

    // Grant number LOCK_MAX of a lock is the one taken with the counter at
    // LOCK_MAX-1; that grant releases the lock whatever lock says.
    localparam logic [3:0] c_lock_last   = 4'(LOCK_MAX - 1);
    // With LOCK_MAX=1 the entering grant already exhausts the lock.
    localparam bit         c_lock_enable = (LOCK_MAX > 1);

    logic [1:0]      r_state;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   r_owner;
    logic [3:0]      r_lock_cnt;
    logic [DW-1:0]   r_rdata;
    logic [NREQ-1:0] r_rvalid;

    logic [NREQ-1:0] w_pick;
    logic [NREQ-1:0] w_owner_oh;
    logic [NREQ-1:0] w_gnt;
    logic            w_any;
    logic            w_gnt_lock;
    logic            w_pending;
    logic            w_wr;
    logic [PW-1:0]   w_gnt_idx;
    logic [AW-1:0]   w_rd_addr;
    logic [DW-1:0]   w_rd_word;
    logic [DW-1:0]   w_init [DEPTH];

    // ------------------------------------------------------------------
    // Table image
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_init
        assign w_init[gi] = DW'(RETTA_MEM_INIT[gi % RETTA_DEPTH]);
    end

`ifdef RETTA_ARB_WR_EN
    logic [DW-1:0] r_table [DEPTH];

    assign w_wr = wr_en;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_table <= w_init;
        end else if (wr_en) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    assign w_rd_word = r_table[w_rd_addr];
`else
    assign w_wr      = 1'b0;
    assign w_rd_word = w_init[w_rd_addr];
`endif

    // ------------------------------------------------------------------
    // Grant generation
    // ------------------------------------------------------------------
    retta_rr_pick #(
        .NREQ   (NREQ),
        .PW     (PW)
    ) u_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .gnt    (w_pick)
    );

    always_comb begin
        w_owner_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_owner_oh[i] = (r_owner == i[PW-1:0]);
        end
    end

    // Grants are held off while reset is asserted so gnt reads zero in reset.
    always_comb begin
        w_gnt = '0;
        if (reset_n && !w_wr) begin
            if (r_state == S_LOCKED) begin
                w_gnt = w_owner_oh & req;
            end else begin
                w_gnt = w_pick;
            end
        end
    end

    assign w_any      = |w_gnt;
    assign w_gnt_lock = |(w_gnt & lock);
    assign w_pending  = |(req & ~w_gnt);

    always_comb begin
        w_gnt_idx = '0;
        w_rd_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx = i[PW-1:0];
                w_rd_addr = addr[i*AW +: AW];
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbiter state, lock counter and read register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= PW'(NREQ - 1);
            r_owner    <= '0;
            r_lock_cnt <= '0;
            r_rdata    <= '0;
            r_rvalid   <= '0;
        end else begin
            r_rvalid <= w_gnt;
            if (w_any) begin
                r_rdata <= w_rd_word;
            end

            // A write cycle freezes arbitration state entirely.
            if (!w_wr) begin
                if (r_state == S_LOCKED) begin
                    // No grant here means the owner dropped its request.
                    if (!w_any || !w_gnt_lock || (r_lock_cnt == c_lock_last)) begin
                        r_state    <= S_SERVE;
                        r_rr_ptr   <= r_owner;
                        r_lock_cnt <= '0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 4'd1;
                    end
                end else if (w_any) begin
                    r_rr_ptr <= w_gnt_idx;
                    if (w_gnt_lock && c_lock_enable) begin
                        r_state    <= S_LOCKED;
                        r_owner    <= w_gnt_idx;
                        r_lock_cnt <= 4'd1;
                    end else begin
                        r_state <= w_pending ? S_SERVE : S_IDLE;
                    end
                end else begin
                    r_state <= S_IDLE;
                end
            end
        end
    end

    assign gnt    = w_gnt;
    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign owner  = r_owner;
    assign locked = (r_state == S_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_retta_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_retta_mem_arbiter
//  Purpose  : Self-checking bench for retta_mem_arbiter (NREQ=2, LOCK_MAX=3)
//             with directed scenarios and randomized traffic compared to a
//             grant-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_retta_mem_arbiter;

    localparam int NREQ     = 2;
    localparam int AW       = 4;
    localparam int DW       = 8;
    localparam int LOCK_MAX = 3;

    logic           clock   = 1'b0;
    logic           reset_n = 1'b0;
    logic [1:0]     req     = '0;
    logic [1:0]     lock    = '0;
    logic [7:0]     addr    = '0;
    logic [1:0]     gnt;
    logic [7:0]     rdata;
    logic [1:0]     rvalid;
    logic           owner;
    logic           locked;
`ifdef RETTA_ARB_WR_EN
    logic           wr_en   = 1'b0;
    logic [3:0]     wr_addr = '0;
    logic [7:0]     wr_data = '0;
`endif

    always #5 clock = ~clock;

    retta_mem_arbiter #(
        .NREQ     (NREQ),
        .AW       (AW),
        .DW       (DW),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
`ifdef RETTA_ARB_WR_EN
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
`endif
        .req      (req),
        .addr     (addr),
        .lock     (lock),
        .gnt      (gnt),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .owner    (owner),
        .locked   (locked)
    );

    int n_total = 0;
    int n_bad   = 0;

    // ---------------- reference model (grant-level) ----------------
    logic [7:0] m_mem [16];
    int         m_last;     // most recent winner; search starts after it
    int         m_owner;    // -1 when not locked
    int         m_cnt;      // grants taken by the current owner
    logic [1:0] m_rvalid;
    logic [7:0] m_rdata;
    logic [1:0] exp_gnt;
    logic [1:0] obs_gnt;

    task automatic model_reset();
        m_mem    = '{8'd1, 8'd255, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0,
                     8'd0, 8'd2, 8'd255, 8'd5, 8'd0, 8'd2, 8'd0, 8'd2};
        m_last   = NREQ - 1;
        m_owner  = -1;
        m_cnt    = 0;
        m_rvalid = '0;
        m_rdata  = '0;
    endtask

    function automatic logic [1:0] model_grant(input logic [1:0] rq, input logic we);
        int cand;
        if (we) return 2'b00;
        if (m_owner >= 0) return rq[m_owner] ? (2'b01 << m_owner) : 2'b00;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (m_last + k) % NREQ;
            if (rq[cand]) return 2'b01 << cand;
        end
        return 2'b00;
    endfunction

    function automatic void model_commit(input logic [1:0] lk, input logic [7:0] ad,
                                         input logic we, input logic [3:0] wa,
                                         input logic [7:0] wd, input logic [1:0] g);
        int w;
        m_rvalid = g;
        if (we) begin
            m_mem[wa] = wd;
            return;
        end
        if (g == 2'b00) begin
            if (m_owner >= 0) begin
                m_last  = m_owner;
                m_owner = -1;
            end
            return;
        end
        w       = g[1] ? 1 : 0;
        m_rdata = m_mem[ad[w*4 +: 4]];
        if (m_owner >= 0) begin
            m_cnt++;
            if (!lk[w] || m_cnt >= LOCK_MAX) begin
                m_last  = w;
                m_owner = -1;
            end
        end else begin
            m_last = w;
            if (lk[w] && LOCK_MAX > 1) begin
                m_owner = w;
                m_cnt   = 1;
            end
        end
    endfunction

    // One bus cycle: drive at negedge, capture the combinational grant, then
    // advance past the rising edge so registered outputs can be examined.
    task automatic tick(input logic [1:0] rq, input logic [1:0] lk, input logic [7:0] ad,
                        input logic we, input logic [3:0] wa, input logic [7:0] wd);
        @(negedge clock);
        req  = rq;
        lock = lk;
        addr = ad;
`ifdef RETTA_ARB_WR_EN
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
`endif
        #1;
        obs_gnt = gnt;
        exp_gnt = model_grant(rq, we);
        @(posedge clock);
        model_commit(lk, ad, we, wa, wd, exp_gnt);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        req     = 2'b01;
        addr    = 8'h01;
        #1;
        n_total++;
        if (gnt !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        @(negedge clock);
        n_total++;
        if (rvalid !== 2'b00 || rdata !== 8'd0 || locked !== 1'b0 || owner !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rvalid=%b rdata=%0d locked=%b owner=%b want 00/0/0/0",
                     rvalid, rdata, locked, owner);
        end
        req     = 2'b00;
        addr    = 8'h00;
        reset_n = 1'b1;
        model_reset();
        for (int c = 0; c < 10; c++) begin
            tick(2'b00, 2'b00, 8'h00, 1'b0, 4'd0, 8'd0);
            n_total++;
            if (obs_gnt !== 2'b00 || rvalid !== 2'b00 || locked !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_quiet: got gnt=%b rvalid=%b locked=%b want 00/00/0",
                         obs_gnt, rvalid, locked);
            end
        end
    endtask

    task automatic test_single_read();
        tick(2'b01, 2'b00, 8'h01, 1'b0, 4'd0, 8'd0);
        n_total++;
        if (obs_gnt !== 2'b01) begin n_bad++; $display("FAIL single_gnt: got %b want 01", obs_gnt); end
        n_total++;
        if (rvalid !== 2'b01 || rdata !== 8'd255) begin
            n_bad++;
            $display("FAIL single_data: got rvalid=%b rdata=%0d want 01/255", rvalid, rdata);
        end
        tick(2'b00, 2'b00, 8'h00, 1'b0, 4'd0, 8'd0);
        n_total++;
        if (rvalid !== 2'b00 || rdata !== 8'd255) begin
            n_bad++;
            $display("FAIL single_hold: got rvalid=%b rdata=%0d want 00/255", rvalid, rdata);
        end
    endtask

    task automatic test_alternate();
        logic [1:0] prev = 2'b00;
        for (int c = 0; c < 4; c++) begin
            tick(2'b11, 2'b00, {4'd10, 4'd9}, 1'b0, 4'd0, 8'd0);
            n_total++;
            if (obs_gnt !== exp_gnt || obs_gnt === prev) begin
                n_bad++;
                $display("FAIL alt_gnt[%0d]: got %b want %b (prev %b)", c, obs_gnt, exp_gnt, prev);
            end
            n_total++;
            if (rvalid !== exp_gnt || rdata !== (exp_gnt == 2'b01 ? 8'd2 : 8'd255)) begin
                n_bad++;
                $display("FAIL alt_data[%0d]: got rvalid=%b rdata=%0d want %b/%0d", c, rvalid, rdata,
                         exp_gnt, (exp_gnt == 2'b01 ? 8'd2 : 8'd255));
            end
            prev = obs_gnt;
        end
        tick(2'b00, 2'b00, 8'h00, 1'b0, 4'd0, 8'd0);
    endtask

    task automatic test_lock_release();
        tick(2'b10, 2'b00, 8'h00, 1'b0, 4'd0, 8'd0);
        tick(2'b11, 2'b01, {4'd0, 4'd10}, 1'b0, 4'd0, 8'd0);
        n_total++;
        if (obs_gnt !== 2'b01 || rdata !== 8'd255 || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL lockrel_first: got gnt=%b rdata=%0d locked=%b want 01/255/1", obs_gnt, rdata, locked);
        end
        tick(2'b11, 2'b00, {4'd0, 4'd11}, 1'b0, 4'd0, 8'd0);
        n_total++;
        if (obs_gnt !== 2'b01 || rdata !== 8'd5 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL lockrel_second: got gnt=%b rdata=%0d locked=%b want 01/5/0", obs_gnt, rdata, locked);
        end
        tick(2'b11, 2'b00, {4'd0, 4'd11}, 1'b0, 4'd0, 8'd0);
        n_total++;
        if (obs_gnt !== 2'b10 || rvalid !== 2'b10 || rdata !== 8'd1) begin
            n_bad++;
            $display("FAIL lockrel_other: got gnt=%b rvalid=%b rdata=%0d want 10/10/1", obs_gnt, rvalid, rdata);
        end
        tick(2'b00, 2'b00, 8'h00, 1'b0, 4'd0, 8'd0);
    endtask

    task automatic test_lock_max();
        logic [2:0] exp_locked = 3'b011;   // locked after grants 1,2 but not 3
        tick(2'b10, 2'b00, 8'h00, 1'b0, 4'd0, 8'd0);
        for (int c = 0; c < 3; c++) begin
            tick(2'b11, 2'b01, {4'd2, 4'd1}, 1'b0, 4'd0, 8'd0);
            n_total++;
            if (obs_gnt !== 2'b01 || locked !== exp_locked[c] || rdata !== 8'd255) begin
                n_bad++;
                $display("FAIL lockmax_grant[%0d]: got gnt=%b locked=%b rdata=%0d want 01/%b/255",
                         c, obs_gnt, locked, rdata, exp_locked[c]);
            end
        end
        tick(2'b11, 2'b01, {4'd2, 4'd1}, 1'b0, 4'd0, 8'd0);
        n_total++;
        if (obs_gnt !== 2'b10 || rdata !== 8'd0 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL lockmax_forced: got gnt=%b rdata=%0d locked=%b want 10/0/0", obs_gnt, rdata, locked);
        end
        tick(2'b11, 2'b01, {4'd2, 4'd1}, 1'b0, 4'd0, 8'd0);
        n_total++;
        if (locked !== 1'b1 || owner !== 1'b0) begin
            n_bad++;
            $display("FAIL lockmax_relock: got locked=%b owner=%b want 1/0", locked, owner);
        end
        // asynchronous reset in the middle of a lock
        #2;
        reset_n = 1'b0;
        #1;
        n_total++;
        if (locked !== 1'b0 || rvalid !== 2'b00 || gnt !== 2'b00 || rdata !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_midlock: got locked=%b rvalid=%b gnt=%b rdata=%0d want 0/00/00/0",
                     locked, rvalid, gnt, rdata);
        end
        req  = 2'b00;
        lock = 2'b00;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        logic [1:0] rq = 2'b00;
        logic [1:0] lk;
        logic [7:0] ad = 8'h00;
        logic [1:0] last_g = 2'b00;
        int         wait_c [2] = '{0, 0};
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(rq[i] && !last_g[i])) begin
                    rq[i]         = ($urandom_range(0, 3) != 0);
                    ad[i*4 +: 4]  = 4'($urandom_range(0, 15));
                end
            end
            lk = 2'($urandom_range(0, 3));
            tick(rq, lk, ad, 1'b0, 4'd0, 8'd0);
            n_total++;
            if (obs_gnt !== exp_gnt) begin
                n_bad++;
                $display("FAIL rand_gnt[%0d]: got %b want %b", c, obs_gnt, exp_gnt);
            end
            n_total++;
            if (rvalid !== m_rvalid || rdata !== m_rdata) begin
                n_bad++;
                $display("FAIL rand_data[%0d]: got rvalid=%b rdata=%0d want %b/%0d",
                         c, rvalid, rdata, m_rvalid, m_rdata);
            end
            n_total++;
            if (locked !== (m_owner >= 0) || (m_owner >= 0 && owner !== m_owner[0])) begin
                n_bad++;
                $display("FAIL rand_lock[%0d]: got locked=%b owner=%b want %b/%0d",
                         c, locked, owner, (m_owner >= 0), m_owner);
            end
            for (int i = 0; i < NREQ; i++) begin
                wait_c[i] = (rq[i] && !obs_gnt[i]) ? wait_c[i] + 1 : 0;
                n_total++;
                if (wait_c[i] > (NREQ - 1) * LOCK_MAX) begin
                    n_bad++;
                    $display("FAIL rand_starve[%0d]: requester %0d waited %0d want <= %0d",
                             c, i, wait_c[i], (NREQ - 1) * LOCK_MAX);
                    wait_c[i] = 0;
                end
            end
            last_g = exp_gnt;
        end
        tick(2'b00, 2'b00, 8'h00, 1'b0, 4'd0, 8'd0);
        tick(2'b00, 2'b00, 8'h00, 1'b0, 4'd0, 8'd0);
    endtask

`ifdef RETTA_ARB_WR_EN
    task automatic test_write();
        tick(2'b01, 2'b00, {4'd0, 4'd5}, 1'b1, 4'd5, 8'd148);
        n_total++;
        if (obs_gnt !== 2'b00 || rvalid !== 2'b00) begin
            n_bad++;
            $display("FAIL write_blocks: got gnt=%b rvalid=%b want 00/00", obs_gnt, rvalid);
        end
        tick(2'b01, 2'b00, {4'd0, 4'd5}, 1'b0, 4'd0, 8'd0);
        n_total++;
        if (obs_gnt !== 2'b01 || rdata !== 8'd148) begin
            n_bad++;
            $display("FAIL write_readback: got gnt=%b rdata=%0d want 01/148", obs_gnt, rdata);
        end
        @(negedge clock);
        req     = 2'b00;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        model_reset();
        tick(2'b01, 2'b00, {4'd0, 4'd5}, 1'b0, 4'd0, 8'd0);
        n_total++;
        if (rdata !== 8'd2 || rvalid !== 2'b01) begin
            n_bad++;
            $display("FAIL write_reset_restore: got rdata=%0d rvalid=%b want 2/01", rdata, rvalid);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_single_read();
        test_alternate();
        test_lock_release();
        test_lock_max();
        test_random();
`ifdef RETTA_ARB_WR_EN
        test_write();
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/retta_mem_arbiter.md
# retta_mem_arbiter

Shares the single-read-port 16×8 point table (the line-check coordinate memory) between NREQ scan engines. Round-robin arbitration with an optional lock, so an engine can fetch an X/Y pair back-to-back. Read data returns one cycle after grant, tagged with a per-requester valid. Sits between the scan engines and the point table. The table itself lives inside this block.

## Interface
- NREQ, 2, number of requesters; legal range 2..4.
- AW, 4, table address width; depth is 2**AW = 16.
- DW, 8, table data width.
- LOCK_MAX, 3, maximum consecutive grants to one locked owner before forced release; legal range 1..15.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester read request; level, held until granted.
- addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- lock  in  NREQ  with req[i]: keep ownership after this grant.
- gnt  out  NREQ  one-hot or zero, combinational; the read is performed this cycle.
- rdata  out  DW  registered read data.
- rvalid  out  NREQ  registered; one-hot; rdata belongs to requester i.
- owner  out  $clog2(NREQ)  current lock owner; valid only when locked=1.
- locked  out  1  arbiter is in S_LOCKED.

## Operation
- States:
  - S_IDLE: no request pending.
  - S_SERVE: arbitrating.
  - S_LOCKED: only the owner may be granted.
- Arbitration in S_IDLE/S_SERVE:
  - Grant the first requester with req=1, searching from rr_ptr+1 modulo NREQ.
  - rr_ptr updates to the granted index.
  - rr_ptr resets to NREQ-1, so requester 0 wins first after reset.
- Transitions:
  - If grant i occurs with lock[i]=1: go to S_LOCKED, owner=i, lock_cnt=1.
  - Otherwise: S_SERVE if any req is pending next cycle, else S_IDLE.
- In S_LOCKED:
  - gnt[owner]=req[owner]; all other gnt bits are 0.
  - Each owner grant increments lock_cnt.
  - Release to S_SERVE when any of these holds:
    - the owner is granted with lock=0;
    - req[owner]=0;
    - lock_cnt reaches LOCK_MAX and this cycle's grant occurs. This release is forced even if lock=1.
  - On release, rr_ptr=owner, so other requesters get priority next.
- Read path: at the grant edge, rdata<=table[addr of grantee] and rvalid<=gnt. When nothing is granted, rvalid=0 and rdata holds its value.
- Table contents (reset/constant), addresses 0..15: 1, 255, 0, 0, 0, 2, 0, 0, 0, 2, 255, 5, 0, 2, 0, 2.
- Addresses are full-range; there is no out-of-range case.
- Reset values: gnt=0, rvalid=0, rdata=0, owner=0, locked=0, state=S_IDLE, lock_cnt=0.

## Timing
- Grant latency: 0 cycles (gnt is asserted in the same cycle as req when the requester wins).
- Data latency: rvalid/rdata are asserted at edge T+1 after a grant in cycle T.
- Throughput: one read per cycle. A locked owner can read on consecutive cycles with no gap.
- Simultaneous requests: exactly one is granted and the losers hold req. Worst-case wait is (NREQ-1)*LOCK_MAX cycles.
- Reset mid-lock: the asynchronous assert clears the lock and any pending rvalid immediately. A grant in the reset-release cycle is allowed.
- The requester must keep addr stable while req=1 and not granted. addr is sampled only at the grant edge.

## Configuration
- RETTA_ARB_WR_EN:
  - Defined: adds ports wr_en (in, 1), wr_addr (in, AW) and wr_data (in, DW). The table becomes registers, loaded with the constant contents on reset.
  - Defined: wr_en has priority. In a wr_en cycle all gnt=0, the state and lock_cnt are unchanged, and the write lands at the edge.
  - Defined: a read of the same address in a later cycle returns the new value.
  - Undefined: the write ports are absent and the table is a constant ROM from the package.

## Structure
- Package retta_pkg:
  - RETTA_MEM_INIT (16×8 constant array);
  - arb state enum (S_IDLE, S_SERVE, S_LOCKED);
  - default AW/DW localparams.
- Sub-module retta_rr_pick: a combinational round-robin picker. It takes req and rr_ptr and returns a one-hot grant. The top holds the FSM, lock counter and table.

## Test plan
- Reset then idle: all outputs 0 and locked=0. No rvalid while req=0 for 10 cycles.
- req[0]=1, addr0=1 → gnt[0] in the same cycle; next cycle rvalid=2'b01, rdata=255.
- req=2'b11 held, no lock → grants alternate 0,1,0,1. rvalid follows one cycle later.
- req0 with lock=1 on addr 10 then lock=0 on addr 11, req1 pending → two consecutive gnt[0] with rdata 255 then 5. Then gnt[1]; locked drops after the second grant.
- req0 lock held at 1 forever, LOCK_MAX=3, req1 pending → exactly 3 gnt[0], then gnt[1].
- RETTA_ARB_WR_EN: write 148 at addr 5 while req0 is pending → gnt=0 that cycle. The next read of addr 5 returns 148. reset_n pulse → addr 5 reads 2.
